pending_encoder_8to3: RTL and testbench
=======================================

// Module: pending_encoder_8to3
// PURPOSE
//  Inverse of the team's 3-to-8 select decoder: collects request strobes on N
//  one-hot lines, latches them as sticky pending bits and emits them one at a
//  time as binary codes over a valid/ready handshake. Sits between event
//  sources (IRQ lines, channel done flags) and a consumer wanting a code.
// PARAMETERS
//  N  8  number of request lines; power of 2, >= 2
//  W  3  code width; must equal log2(N)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  async active-low reset
//  req_i        in   N  request strobes, sampled every edge; any bit pattern legal
//  out_ready_i  in   1  consumer accepts out_code_o this cycle
//  out_valid_o  out  1  out_code_o holds a valid code
//  out_code_o   out  W  binary index of the served request line
//  pending_o    out  N  latched, not-yet-issued requests
//  drop_o       out  1  1-cycle pulse: request hit an already-pending bit
// BEHAVIOUR
//  - Reset (async assert, sync release): pending_o=0, out_valid_o=0,
//    out_code_o=0, drop_o=0, FSM=IDLE, RR pointer=N-1. Reset mid-handshake
//    discards the held code and all pending bits.
//  - Every edge: pending <= (pending & ~clr_mask) | req_i. New req wins over
//    clear on the same bit (bit stays pending).
//  - drop_o <= |(req_i & pending & ~clr_mask); registered, high for one cycle.
//  - The code currently held on out_code_o is not pending; a new req for it
//    re-pends (no drop).
//  - FSM, 2 states:
//    IDLE: out_valid_o=0. If pending!=0: sel=select(pending),
//          out_code_o<=sel, clr_mask=onehot(sel), out_valid_o<=1, ->HOLD.
//    HOLD: out_valid_o=1, out_code_o stable while !out_ready_i.
//          On out_ready_i: if pending!=0, load next sel at the same edge and
//          stay HOLD (one code per cycle); else out_valid_o<=0, ->IDLE.
//  - clr_mask=0 on any edge that loads no code.
//  - Latency: req_i sampled at edge E0 -> out_valid_o=1 after E1 (IDLE case).
//  - select(): fixed priority, lowest index first.
//  - Selection uses registered pending only; req_i in the same cycle is not
//    eligible until the next edge.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: select() scans from (ptr+1) mod N upward with
//    wrap-around. ptr <= sel on every load. After reset, the first scan
//    starts at index 0.
//  ROUND_ROBIN_EN undefined: fixed lowest-index priority, no pointer
//    register. Identical behaviour until the first load.
// TESTING
//  1 reset asserted mid-HOLD with pending=8'hF0 -> all outputs 0
//    immediately; after release no valid until a new req.
//  2 req_i=8'h04 for 1 cycle, ready=1 -> out_valid_o=1, code=2 at E1;
//    out_valid_o=0 after E2; pending_o=0.
//  3 req_i=8'h92 for 1 cycle, ready=1, fixed priority -> codes 1,4,7 on
//    3 consecutive cycles, then valid=0.
//  4 req_i=8'h81, ready=0 for 5 cycles -> code=0 held stable, pending_o=8'h80;
//    raise ready -> code=7 next cycle.
//  5 req_i[3] pulsed twice while bit 3 pending -> drop_o=1 for exactly one
//    cycle; bit 3 issued once.
//  6 ROUND_ROBIN_EN: serve code 0, then req_i=8'h03 -> code 1 issued before 0;
//    undefined -> 0 before 1.

Source files
------------

// File: rtl/pending_encoder_8to3.sv
// Sticky request collector that issues pending lines one at a time as binary codes over valid/ready.
// Latency: a request sampled at edge E0 is presented on out_code_o after E1, one code per cycle under ready.
// Backpressure: with out_ready_i low the held code stays stable and new requests accumulate; define ROUND_ROBIN_EN for rotating priority.
module pending_encoder_8to3 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_code_o,
    output logic [N-1:0] pending_o,
    output logic         drop_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   clr_mask;
    logic [W-1:0]   code_q;
    logic [W-1:0]   sel;
    logic           drop_q;
    logic           any_pending;
    logic           load;

    assign any_pending = |pending_q;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] idx;
    logic         found;

    // N is a power of two, so the W-bit sum wraps modulo N for free.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + W'(1) + W'(i);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Reset to N-1 so the first scan starts at line 0, matching fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '1;
        end else if (load) begin
            ptr_q <= sel;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            // A fresh request on the bit being cleared keeps it pending.
            pending_q <= (pending_q & ~clr_mask) | req_i;
            drop_q    <= |(req_i & pending_q & ~clr_mask);
            if (load) begin
                code_q <= sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_pending) state_d = HOLD;
            HOLD: if (out_ready_i && !any_pending) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load     = any_pending && ((state_q == IDLE) || out_ready_i);
        clr_mask = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
    end

    assign out_valid_o = (state_q == HOLD);
    assign out_code_o  = code_q;
    assign pending_o   = pending_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// Directed bench for pending_encoder_8to3: inputs driven and outputs sampled on the falling edge.
module tb_pending_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       out_ready_i;
    logic       out_valid_o;
    logic [2:0] out_code_o;
    logic [7:0] pending_o;
    logic       drop_o;

    int checks = 0;
    int errors = 0;

    pending_encoder_8to3 #(.N(8), .W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_code_o  (out_code_o),
        .pending_o   (pending_o),
        .drop_o      (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_i = 8'h00;
        out_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_i = 8'h00;
        out_ready_i = 1'b0;
        reset_dut();
        check("rst_valid", out_valid_o, 0);
        check("rst_code", out_code_o, 0);
        check("rst_pending", pending_o, 8'h00);
        check("rst_drop", drop_o, 0);

        // single request, one cycle through
        req_i = 8'h04; out_ready_i = 1'b1;
        step();
        check("t2_pend_e0", pending_o, 8'h04);
        check("t2_valid_e0", out_valid_o, 0);
        req_i = 8'h00;
        step();
        check("t2_valid_e1", out_valid_o, 1);
        check("t2_code_e1", out_code_o, 2);
        check("t2_pend_e1", pending_o, 8'h00);
        step();
        check("t2_valid_e2", out_valid_o, 0);
        check("t2_pend_e2", pending_o, 8'h00);

        // three lines, fixed order from reset
        reset_dut();
        req_i = 8'h92; out_ready_i = 1'b1;
        step();
        req_i = 8'h00;
        step();
        check("t3_code_a", out_code_o, 1);
        check("t3_valid_a", out_valid_o, 1);
        step();
        check("t3_code_b", out_code_o, 4);
        step();
        check("t3_code_c", out_code_o, 7);
        check("t3_pend_c", pending_o, 8'h00);
        step();
        check("t3_valid_end", out_valid_o, 0);

        // backpressure holds the code
        reset_dut();
        req_i = 8'h81; out_ready_i = 1'b0;
        step();
        req_i = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_code", out_code_o, 0);
            check("t4_hold_valid", out_valid_o, 1);
            check("t4_hold_pend", pending_o, 8'h80);
        end
        out_ready_i = 1'b1;
        step();
        check("t4_next_code", out_code_o, 7);
        check("t4_next_pend", pending_o, 8'h00);
        step();
        check("t4_valid_end", out_valid_o, 0);

        // drop on duplicate request, bit issued once
        reset_dut();
        req_i = 8'h01; out_ready_i = 1'b0;
        step();
        req_i = 8'h00;
        step();
        req_i = 8'h08;
        step();
        check("t5_drop_first", drop_o, 0);
        check("t5_pend_first", pending_o, 8'h08);
        step();
        check("t5_drop_second", drop_o, 1);
        req_i = 8'h00;
        step();
        check("t5_drop_clear", drop_o, 0);
        check("t5_pend_hold", pending_o, 8'h08);
        out_ready_i = 1'b1;
        step();
        check("t5_code3", out_code_o, 3);
        check("t5_valid3", out_valid_o, 1);
        step();
        check("t5_once", out_valid_o, 0);
        check("t5_pend_end", pending_o, 8'h00);

        // new request beats clear on the loaded bit
        reset_dut();
        req_i = 8'h04; out_ready_i = 1'b1;
        step();
        step();
        check("nw_code", out_code_o, 2);
        check("nw_pend", pending_o, 8'h04);
        check("nw_drop", drop_o, 0);
        req_i = 8'h00;
        step();
        check("nw_reissue_valid", out_valid_o, 1);
        check("nw_reissue_code", out_code_o, 2);
        check("nw_reissue_pend", pending_o, 8'h00);
        step();
        check("nw_valid_end", out_valid_o, 0);

        // held code re-pends without drop
        reset_dut();
        req_i = 8'h01; out_ready_i = 1'b0;
        step();
        req_i = 8'h00;
        step();
        req_i = 8'h01;
        step();
        check("rp_drop", drop_o, 0);
        check("rp_pend", pending_o, 8'h01);
        check("rp_code", out_code_o, 0);
        req_i = 8'h00; out_ready_i = 1'b1;
        step();
        check("rp_again_code", out_code_o, 0);
        check("rp_again_valid", out_valid_o, 1);
        step();
        check("rp_valid_end", out_valid_o, 0);

        // reset in the middle of a hold
        reset_dut();
        req_i = 8'hF2; out_ready_i = 1'b0;
        step();
        req_i = 8'h00;
        step();
        check("t1_pre_pend", pending_o, 8'hF0);
        check("t1_pre_code", out_code_o, 1);
        check("t1_pre_valid", out_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("t1_valid", out_valid_o, 0);
        check("t1_code", out_code_o, 0);
        check("t1_pend", pending_o, 8'h00);
        check("t1_drop", drop_o, 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        step();
        step();
        check("t1_post_valid", out_valid_o, 0);
        check("t1_post_pend", pending_o, 8'h00);

        // arbitration order after serving line 0
        reset_dut();
        req_i = 8'h01; out_ready_i = 1'b1;
        step();
        req_i = 8'h00;
        step();
        check("t6_first", out_code_o, 0);
        req_i = 8'h03;
        step();
        check("t6_gap_valid", out_valid_o, 0);
        req_i = 8'h00;
        step();
`ifdef ROUND_ROBIN_EN
        check("t6_order_a", out_code_o, 1);
        step();
        check("t6_order_b", out_code_o, 0);
`else
        check("t6_order_a", out_code_o, 0);
        step();
        check("t6_order_b", out_code_o, 1);
`endif
        step();
        check("t6_valid_end", out_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
